// File: rtl/parking_gate_ctrl_if.sv
// Signal bundle between the entry sensors/keypad, the parking gate controller
// and the barrier/alarm side.
//
// Handshake: digit_valid is a valid-only strobe. The controller is always
// ready, so every cycle with digit_valid high delivers exactly one digit.
// Digits arriving while the controller is not collecting a PIN are dropped.
interface parking_gate_ctrl_if #(
    parameter int DIGIT_W = 4,
    parameter int TRIES_W = 2
);
    logic               arrival;
    logic               passed;
    logic               digit_valid;
    logic [DIGIT_W-1:0] digit;
    logic               gate_open;
    logic               block_alarm;
    logic               pin_alarm;
    logic               wrong_pin;
    logic [TRIES_W-1:0] tries;
    logic [2:0]         state_dbg;

    // Sensor/keypad side: drives the inputs, observes the outputs.
    modport master (
        output arrival, passed, digit_valid, digit,
        input  gate_open, block_alarm, pin_alarm, wrong_pin, tries, state_dbg
    );

    // Controller side.
    modport slave (
        input  arrival, passed, digit_valid, digit,
        output gate_open, block_alarm, pin_alarm, wrong_pin, tries, state_dbg
    );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: collects a multi-digit PIN from the keypad, raises
// the barrier on a match, counts wrong attempts up to a lockout, times out
// idle keying and an unused open gate, and blocks on tailgating.
// All outputs are registered; state_dbg exposes the FSM state.
module parking_gate_ctrl #(
    parameter int                           DIGIT_W   = 4,
    parameter int                           PIN_LEN   = 4,
    parameter logic [DIGIT_W*PIN_LEN-1:0]   PIN       = 16'h2024,
    parameter int                           MAX_TRIES = 3,
    parameter int                           ENTRY_TO  = 15,
    parameter int                           OPEN_TO   = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    parking_gate_ctrl_if.slave   gif
);

    localparam int PIN_W   = DIGIT_W * PIN_LEN;
    localparam int CNT_W   = $clog2(PIN_LEN + 1);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int T_MAX   = (ENTRY_TO > OPEN_TO) ? ENTRY_TO : OPEN_TO;
    localparam int TMR_W   = $clog2(T_MAX + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PIN_ENTRY = 3'd1;
    localparam logic [2:0] S_GATE_OPEN = 3'd2;
    localparam logic [2:0] S_BLOCK     = 3'd3;
    localparam logic [2:0] S_LOCKOUT   = 3'd4;

    logic [2:0]         state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [PIN_W-1:0]   pin_buf_q, pin_buf_n;
    logic [TMR_W-1:0]   timer_q, timer_n;
    logic [TRIES_W-1:0] tries_q, tries_n;
    logic               wrong_q, wrong_n;
    logic               gate_q, block_q, lock_q;

    logic [PIN_W-1:0]   cand;
    logic               last_digit;
    logic               pin_ok;
    logic [TRIES_W-1:0] tries_inc;

    // Candidate PIN if the current digit completes the attempt.
    assign cand       = (pin_buf_q << DIGIT_W) | PIN_W'(gif.digit);
    assign last_digit = gif.digit_valid && (cnt_q == CNT_W'(PIN_LEN - 1));
    assign pin_ok     = (cand == PIN);
    // Wrong-attempt counter saturates at the lockout threshold.
    assign tries_inc  = (tries_q == TRIES_W'(MAX_TRIES)) ? tries_q : tries_q + 1'b1;

    // Next-state and datapath decisions for the gate FSM.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        pin_buf_n = pin_buf_q;
        timer_n   = timer_q;
        tries_n   = tries_q;
        wrong_n   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gif.arrival) begin
                    state_n   = S_PIN_ENTRY;
                    cnt_n     = '0;
                    timer_n   = '0;
                    pin_buf_n = '0;
                end
            end
            S_PIN_ENTRY: begin
                if (!gif.arrival) begin
                    // Vehicle left: discard the partial entry, keep the try count.
                    state_n   = S_IDLE;
                    cnt_n     = '0;
                    timer_n   = '0;
                    pin_buf_n = '0;
                end else if (gif.digit_valid) begin
                    // A digit always beats a simultaneous timer expiry.
                    timer_n = '0;
                    if (last_digit) begin
                        cnt_n     = '0;
                        pin_buf_n = '0;
                        if (pin_ok) begin
                            state_n = S_GATE_OPEN;
                            tries_n = '0;
                        end else begin
                            wrong_n = 1'b1;
                            tries_n = tries_inc;
                            if (tries_inc == TRIES_W'(MAX_TRIES))
                                state_n = S_LOCKOUT;
                        end
                    end else begin
                        cnt_n     = cnt_q + 1'b1;
                        pin_buf_n = cand;
                    end
                end else if (timer_q == TMR_W'(ENTRY_TO - 1)) begin
                    // Keying stalled: treated exactly like a wrong PIN.
                    timer_n   = '0;
                    cnt_n     = '0;
                    pin_buf_n = '0;
                    wrong_n   = 1'b1;
                    tries_n   = tries_inc;
                    if (tries_inc == TRIES_W'(MAX_TRIES))
                        state_n = S_LOCKOUT;
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end
            S_GATE_OPEN: begin
                if (gif.passed) begin
                    // A second vehicle still on the entry sensor is a tailgate.
                    state_n = gif.arrival ? S_BLOCK : S_IDLE;
                    timer_n = '0;
                end else if (timer_q == TMR_W'(OPEN_TO - 1)) begin
                    state_n = S_IDLE;
                    timer_n = '0;
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end
            S_BLOCK, S_LOCKOUT: begin
                // Attendant unlock: correct PIN only, no timeout, no try counting.
                if (gif.digit_valid) begin
                    if (last_digit) begin
                        cnt_n     = '0;
                        pin_buf_n = '0;
                        if (pin_ok) begin
                            state_n = S_IDLE;
                            if (state_q == S_LOCKOUT)
                                tries_n = '0;
                        end
                    end else begin
                        cnt_n     = cnt_q + 1'b1;
                        pin_buf_n = cand;
                    end
                end
            end
            default: begin
                state_n   = S_IDLE;
                cnt_n     = '0;
                pin_buf_n = '0;
                timer_n   = '0;
            end
        endcase
    end

    // State, datapath and registered outputs; reset overrides everything.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pin_buf_q <= '0;
            timer_q   <= '0;
            tries_q   <= '0;
            wrong_q   <= 1'b0;
            gate_q    <= 1'b0;
            block_q   <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            pin_buf_q <= pin_buf_n;
            timer_q   <= timer_n;
            tries_q   <= tries_n;
            wrong_q   <= wrong_n;
            gate_q    <= (state_n == S_GATE_OPEN);
            block_q   <= (state_n == S_BLOCK);
            lock_q    <= (state_n == S_LOCKOUT);
        end
    end

    assign gif.gate_open   = gate_q;
    assign gif.block_alarm = block_q;
    assign gif.pin_alarm   = lock_q;
    assign gif.wrong_pin   = wrong_q;
    assign gif.tries       = tries_q;
    assign gif.state_dbg   = state_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl. Inputs change 1ns after a rising
// edge; outputs are sampled 1ns after the edge that registered them.
module tb_parking_gate_ctrl;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PIN_ENTRY = 3'd1;
    localparam logic [2:0] S_GATE_OPEN = 3'd2;
    localparam logic [2:0] S_BLOCK     = 3'd3;
    localparam logic [2:0] S_LOCKOUT   = 3'd4;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    parking_gate_ctrl_if #(.DIGIT_W(4), .TRIES_W(2)) gif ();

    parking_gate_ctrl #(
        .DIGIT_W(4), .PIN_LEN(4), .PIN(16'h2024),
        .MAX_TRIES(3), .ENTRY_TO(15), .OPEN_TO(15)
    ) dut (
        .clock (clock),
        .reset (reset),
        .gif   (gif)
    );

    // Clock and run-time bound.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic key_digit(input logic [3:0] d);
        gif.digit_valid = 1'b1;
        gif.digit       = d;
        tick();
        gif.digit_valid = 1'b0;
        gif.digit       = 4'h0;
    endtask

    task automatic key_pin(input logic [15:0] p);
        key_digit(p[15:12]);
        key_digit(p[11:8]);
        key_digit(p[7:4]);
        key_digit(p[3:0]);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({gif.gate_open, gif.block_alarm, gif.pin_alarm, gif.wrong_pin} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {gif.gate_open, gif.block_alarm, gif.pin_alarm, gif.wrong_pin});
        end
        checks++;
        if (gif.tries !== 2'd0 || gif.state_dbg !== S_IDLE) begin
            errors++;
            $display("FAIL reset_state: tries=%0d state=%0d expected 0/0", gif.tries, gif.state_dbg);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_open_pass();
        gif.arrival = 1'b1;
        tick();
        checks++;
        if (gif.state_dbg !== S_PIN_ENTRY) begin
            errors++;
            $display("FAIL arrival_entry: state=%0d expected %0d", gif.state_dbg, S_PIN_ENTRY);
        end
        key_digit(4'd2);
        key_digit(4'd0);
        key_digit(4'd2);
        checks++;
        if (gif.gate_open !== 1'b0) begin
            errors++;
            $display("FAIL partial_pin_closed: gate_open=%b expected 0", gif.gate_open);
        end
        key_digit(4'd4);
        checks++;
        if (gif.gate_open !== 1'b1 || gif.state_dbg !== S_GATE_OPEN) begin
            errors++;
            $display("FAIL good_pin_open: gate_open=%b state=%0d expected 1/%0d",
                     gif.gate_open, gif.state_dbg, S_GATE_OPEN);
        end
        gif.passed  = 1'b1;
        gif.arrival = 1'b0;
        tick();
        gif.passed  = 1'b0;
        checks++;
        if (gif.gate_open !== 1'b0 || gif.state_dbg !== S_IDLE) begin
            errors++;
            $display("FAIL pass_close: gate_open=%b state=%0d expected 0/%0d",
                     gif.gate_open, gif.state_dbg, S_IDLE);
        end
    endtask

    task automatic test_lockout();
        gif.arrival = 1'b1;
        tick();
        for (int a = 1; a <= 3; a++) begin
            key_pin(16'h1111);
            checks++;
            if (gif.wrong_pin !== 1'b1 || gif.tries !== 2'(a)) begin
                errors++;
                $display("FAIL wrong_attempt_%0d: wrong_pin=%b tries=%0d expected 1/%0d",
                         a, gif.wrong_pin, gif.tries, a);
            end
            checks++;
            if (gif.pin_alarm !== (a == 3)) begin
                errors++;
                $display("FAIL pin_alarm_after_%0d: got %b expected %b", a, gif.pin_alarm, (a == 3));
            end
            tick();
            checks++;
            if (gif.wrong_pin !== 1'b0) begin
                errors++;
                $display("FAIL wrong_pulse_width_%0d: wrong_pin=%b expected 0", a, gif.wrong_pin);
            end
        end
        key_pin(16'h2024);
        checks++;
        if (gif.pin_alarm !== 1'b0 || gif.tries !== 2'd0 || gif.state_dbg !== S_IDLE) begin
            errors++;
            $display("FAIL lockout_unlock: pin_alarm=%b tries=%0d state=%0d expected 0/0/%0d",
                     gif.pin_alarm, gif.tries, gif.state_dbg, S_IDLE);
        end
        gif.arrival = 1'b0;
        tick();
    endtask

    task automatic test_tailgate();
        gif.arrival = 1'b1;
        tick();
        key_pin(16'h2024);
        gif.passed = 1'b1;
        tick();
        gif.passed = 1'b0;
        checks++;
        if (gif.block_alarm !== 1'b1 || gif.gate_open !== 1'b0 || gif.state_dbg !== S_BLOCK) begin
            errors++;
            $display("FAIL tailgate_block: block_alarm=%b gate_open=%b state=%0d expected 1/0/%0d",
                     gif.block_alarm, gif.gate_open, gif.state_dbg, S_BLOCK);
        end
        key_pin(16'h9999);
        checks++;
        if (gif.wrong_pin !== 1'b0 || gif.tries !== 2'd0 || gif.block_alarm !== 1'b1) begin
            errors++;
            $display("FAIL block_wrong_pin: wrong_pin=%b tries=%0d block_alarm=%b expected 0/0/1",
                     gif.wrong_pin, gif.tries, gif.block_alarm);
        end
        key_pin(16'h2024);
        checks++;
        if (gif.block_alarm !== 1'b0 || gif.state_dbg !== S_IDLE) begin
            errors++;
            $display("FAIL block_unlock: block_alarm=%b state=%0d expected 0/%0d",
                     gif.block_alarm, gif.state_dbg, S_IDLE);
        end
        gif.arrival = 1'b0;
        tick();
    endtask

    task automatic test_entry_timeout();
        gif.arrival = 1'b1;
        tick();
        key_digit(4'd2);
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (gif.wrong_pin !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: wrong_pin=%b expected 0 after 14 idle cycles", gif.wrong_pin);
        end
        tick();
        checks++;
        if (gif.wrong_pin !== 1'b1 || gif.tries !== 2'd1) begin
            errors++;
            $display("FAIL timeout_fires: wrong_pin=%b tries=%0d expected 1/1", gif.wrong_pin, gif.tries);
        end
        key_digit(4'd2);
        for (int i = 0; i < 14; i++) tick();
        key_digit(4'd0);
        checks++;
        if (gif.wrong_pin !== 1'b0 || gif.tries !== 2'd1) begin
            errors++;
            $display("FAIL digit_beats_timeout: wrong_pin=%b tries=%0d expected 0/1", gif.wrong_pin, gif.tries);
        end
        key_digit(4'd2);
        key_digit(4'd4);
        checks++;
        if (gif.gate_open !== 1'b1 || gif.tries !== 2'd0) begin
            errors++;
            $display("FAIL late_digit_kept: gate_open=%b tries=%0d expected 1/0", gif.gate_open, gif.tries);
        end
        gif.passed  = 1'b1;
        gif.arrival = 1'b0;
        tick();
        gif.passed  = 1'b0;
        tick();
    endtask

    task automatic test_open_timeout();
        gif.arrival = 1'b1;
        tick();
        key_pin(16'h2024);
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (gif.gate_open !== 1'b1) begin
            errors++;
            $display("FAIL open_hold: gate_open=%b expected 1 on open cycle 15", gif.gate_open);
        end
        tick();
        gif.arrival = 1'b0;
        checks++;
        if (gif.gate_open !== 1'b0 || gif.state_dbg !== S_IDLE) begin
            errors++;
            $display("FAIL open_timeout: gate_open=%b state=%0d expected 0/%0d",
                     gif.gate_open, gif.state_dbg, S_IDLE);
        end
        tick();
    endtask

    task automatic test_reset_in_lockout();
        gif.arrival = 1'b1;
        tick();
        key_pin(16'h1111);
        key_pin(16'h1111);
        key_pin(16'h1111);
        checks++;
        if (gif.state_dbg !== S_LOCKOUT || gif.pin_alarm !== 1'b1) begin
            errors++;
            $display("FAIL reach_lockout: state=%0d pin_alarm=%b expected %0d/1",
                     gif.state_dbg, gif.pin_alarm, S_LOCKOUT);
        end
        key_digit(4'd2);
        key_digit(4'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if ({gif.gate_open, gif.block_alarm, gif.pin_alarm, gif.wrong_pin} !== 4'b0000 ||
            gif.tries !== 2'd0 || gif.state_dbg !== S_IDLE) begin
            errors++;
            $display("FAIL reset_lockout: outs=%b tries=%0d state=%0d expected 0000/0/0",
                     {gif.gate_open, gif.block_alarm, gif.pin_alarm, gif.wrong_pin},
                     gif.tries, gif.state_dbg);
        end
    endtask

    task automatic test_back_to_back();
        gif.arrival = 1'b1;
        tick();
        key_pin(16'h2024);
        checks++;
        if (gif.gate_open !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_entry: gate_open=%b expected 1", gif.gate_open);
        end
        gif.passed  = 1'b1;
        gif.arrival = 1'b0;
        tick();
        gif.passed  = 1'b0;
        checks++;
        if (gif.gate_open !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_close: gate_open=%b expected 0", gif.gate_open);
        end
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        reset           = 1'b0;
        gif.arrival     = 1'b0;
        gif.passed      = 1'b0;
        gif.digit_valid = 1'b0;
        gif.digit       = 4'h0;
        test_reset();
        test_open_pass();
        test_lockout();
        test_tailgate();
        test_entry_timeout();
        test_open_timeout();
        test_reset_in_lockout();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
